// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: instruction memory with NOP clear engine, word programming port and registered faulting fetch
module instr_mem_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP = 32'h00000013,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  fetch_en,
   input  logic                  stall,
   output logic [DATA_WIDTH-1:0] instr,
   output logic                  instr_valid,
   output logic                  fault_misaligned,
   output logic                  fault_range,
   input  logic                  prog_en,
   input  logic [IDX_W-1:0]      prog_addr,
   input  logic [DATA_WIDTH-1:0] prog_data,
   output logic                  prog_ack,
   output logic                  busy
);
   typedef enum logic {CLEAR, READY} state_t;
   state_t state, state_n;
   logic [IDX_W-1:0] cnt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic mis, rng;
   logic [IDX_W-1:0] idx;
   assign busy = state == CLEAR;
   assign mis = |pc[1:0];
   assign rng = (pc >> 2) >= ADDR_WIDTH'(DEPTH);
   assign idx = pc[IDX_W+1:2];
   always_comb begin
      state_n = state;
      if (state == CLEAR && cnt == IDX_W'(DEPTH - 1)) state_n = READY;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= CLEAR;
         cnt <= '0;
      end else begin
         state <= state_n;
         if (busy) cnt <= cnt + 1'b1;
      end
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (busy) mem[cnt] <= NOP;
         else if (prog_en) mem[prog_addr] <= prog_data;
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         instr <= NOP;
         instr_valid <= 1'b0;
         fault_misaligned <= 1'b0;
         fault_range <= 1'b0;
         prog_ack <= 1'b0;
      end else begin
         prog_ack <= !busy && prog_en;
         if (!busy && !stall) begin
            instr_valid <= fetch_en;
            if (fetch_en) begin
               instr <= (mis || rng) ? NOP : mem[idx];
               fault_misaligned <= mis;
               fault_range <= rng && !mis;
            end
         end
      end
   end
endmodule

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Parametrised instruction memory with a sequential clear engine, a word-write programming port and a registered fetch port with fault detection. It sits between the PC register and the decode stage of the datapath. It is the generalised replacement for the fixed 32×32 instruction array: width and depth are configurable, reset clears memory to NOP, the program is loaded at run time, and fetch supports stall, validity and fault reporting.

## Interface
- DATA_WIDTH, 32, instruction word width in bits
- ADDR_WIDTH, 32, PC width in bits
- DEPTH, 32, number of instruction words; power of two, ≥ 2
- NOP, 32'h00000013, fill value and fault substitute (addi x0,x0,0)
- IDX_W, $clog2(DEPTH), word-index width (derived, not overridable)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- pc  in  ADDR_WIDTH  byte address of the instruction to fetch
- fetch_en  in  1  fetch request this cycle
- stall  in  1  hold the current fetch output
- instr  out  DATA_WIDTH  fetched instruction (registered)
- instr_valid  out  1  instr holds a fetch result
- fault_misaligned  out  1  the last fetch had pc[1:0] ≠ 0
- fault_range  out  1  the last fetch had word index (pc>>2) ≥ DEPTH
- prog_en  in  1  program-write request
- prog_addr  in  IDX_W  word index to write
- prog_data  in  DATA_WIDTH  word to write
- prog_ack  out  1  one-cycle pulse confirming the write
- busy  out  1  clear engine is running

## Operation
- State machine states:
  - CLEAR: entered every cycle that reset is 1. The counter is forced to 0 and no write happens while reset is high.
  - CLEAR with reset 0: each cycle writes mem[cnt] ← NOP and increments cnt. After the write at cnt = DEPTH−1, the state moves to READY.
  - READY: stays in READY until the next reset.
- busy = (state == CLEAR).
- Fetch in READY, when fetch_en=1 and stall=0, updates the outputs on the next edge:
  - Misaligned PC: instr ← NOP, fault_misaligned ← 1, instr_valid ← 1.
  - Otherwise, index ≥ DEPTH (compare the full pc>>2 value, no truncation): instr ← NOP, fault_range ← 1, instr_valid ← 1.
  - Otherwise: instr ← mem[pc>>2], both faults ← 0, instr_valid ← 1.
  - If both faults apply, only fault_misaligned is set.
- Fetch in READY with fetch_en=0 and stall=0: instr_valid ← 0. instr and the fault flags hold their values.
- stall=1: instr, instr_valid and both fault flags hold. Stall takes priority over fetch_en.
- Fetch while busy: ignored. instr_valid stays 0.
- Programming in READY with prog_en=1: mem[prog_addr] ← prog_data, and prog_ack is 1 on the next cycle.
- Programming while busy: the write is dropped and no ack is generated.
- Write and fetch to the same word in the same cycle: the fetch returns the old contents (read-before-write). The new word is visible from the following fetch onward.
- Back-to-back prog_en is legal. Each cycle produces its own write and its own ack pulse.

## Timing
- Reset values: instr = NOP, instr_valid = 0, fault_misaligned = 0, fault_range = 0, prog_ack = 0, busy = 1.
- busy stays high for exactly DEPTH cycles after the first clock edge with reset=0. Fetch and program requests are accepted from the next cycle on.
- Fetch latency: 1 cycle. A request sampled at edge N appears on instr/instr_valid after edge N. Full throughput is one fetch per cycle.
- prog_ack latency: 1 cycle after the write edge. Pulse width is 1 cycle per write.
- Reset asserted mid-clear or mid-run:
  - The clear restarts from index 0 and all contents return to NOP.
  - A pending prog_ack is cancelled.
  - A write or fetch sampled in the same cycle as reset is discarded.
- Memory is inferred as a synchronous-write array. No initial-block contents are relied on; the clear engine is the only initialisation.

## Test plan
- Reset clear (DEPTH=32):
  - Stimulus: hold reset 3 cycles, release, then fetch pc=0x7C after busy falls.
  - Required: busy is high for exactly 32 cycles; instr=0x00000013 with valid=1 and no faults.
- Program and fetch:
  - Stimulus: write 0x001080B3 to index 0 and 0x00208133 to index 1, then fetch pc=0 and pc=4 on consecutive cycles.
  - Required: prog_ack pulses twice; instr gives 0x001080B3 then 0x00208133, one cycle after each request.
- Faults:
  - Stimulus: fetch pc=0x6, then pc=0x80 (DEPTH=32), then pc=0x82.
  - Required outputs, in order: NOP with misaligned=1; NOP with range=1; NOP with misaligned=1 and range=0.
- Stall:
  - Stimulus: fetch pc=4 (holds 0x00208133), then assert stall for 3 cycles while pc=0.
  - Required: instr holds 0x00208133 and valid holds 1 throughout; the fetch of pc=0 completes one cycle after stall drops.
- Collision:
  - Stimulus: in one cycle, write 0xDEADBEEF to index 2 and fetch pc=8 (old 0x13); fetch pc=8 again the next cycle.
  - Required: first fetch returns 0x00000013, second returns 0xDEADBEEF.
- Reset mid-operation:
  - Stimulus: during the clear, assert prog_en to index 5; after READY, assert reset for 1 cycle; then fetch pc=0 after busy falls.
  - Required: the write during clear gives no ack and index 5 reads NOP; the reset restarts the full 32-cycle clear; the fetch of pc=0 returns NOP.
